mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter for a single-port synchronous memory with
// registered strobes and a 2-stage read tag pipeline. Optional MEM_PORT_ARBITER_STARVE_EN.
module mem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              fetch_wins;
    logic              if_xfer, d_xfer;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              tag1_vld_q, tag1_vld_d;
    logic              tag1_fetch_q, tag1_fetch_d;
    logic              tag2_vld_q, tag2_vld_d;
    logic              tag2_fetch_q, tag2_fetch_d;

    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

`ifdef MEM_PORT_ARBITER_STARVE_EN
    localparam int CNT_RAW = $clog2(STARVE_MAX + 1);
    localparam int CNT_W   = (CNT_RAW < 2) ? 2 : CNT_RAW;

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    always_comb fetch_wins = if_req && (starve_cnt_q == CNT_W'(STARVE_MAX));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (if_xfer || !if_req)
            starve_cnt_d = '0;
        else if (d_xfer)
            starve_cnt_d = starve_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) starve_cnt_q <= '0;
        else     starve_cnt_q <= starve_cnt_d;
    end
`else
    localparam int starve_max_unused = STARVE_MAX;

    always_comb fetch_wins = 1'b0;
`endif

    always_comb begin
        d_gnt  = 1'b0;
        if_gnt = 1'b0;
        if (!rst && !halt) begin
            d_gnt  = d_req && !fetch_wins;
            if_gnt = if_req && !d_gnt;
        end
    end

    always_comb begin
        if_xfer = if_req && if_gnt;
        d_xfer  = d_req && d_gnt;
    end

    always_comb begin
        mem_en_d    = if_xfer || d_xfer;
        mem_we_d    = d_xfer && d_we;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (d_xfer)
            mem_addr_d = d_addr;
        else if (if_xfer)
            mem_addr_d = if_addr;
        if (d_xfer && d_we)
            mem_wdata_d = d_wdata;

        // Tag follows the read through the memory's one-cycle read latency.
        tag1_vld_d   = mem_en_d && !mem_we_d;
        tag1_fetch_d = if_xfer;
        tag2_vld_d   = tag1_vld_q;
        tag2_fetch_d = tag1_fetch_q;

        if_rvalid_d = tag2_vld_q && tag2_fetch_q;
        d_rvalid_d  = tag2_vld_q && !tag2_fetch_q;
        if_rdata_d  = if_rvalid_d ? mem_rdata : if_rdata_q;
        d_rdata_d   = d_rvalid_d  ? mem_rdata : d_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            tag1_vld_q   <= 1'b0;
            tag1_fetch_q <= 1'b0;
            tag2_vld_q   <= 1'b0;
            tag2_fetch_q <= 1'b0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            tag1_vld_q   <= tag1_vld_d;
            tag1_fetch_q <= tag1_fetch_d;
            tag2_vld_q   <= tag2_vld_d;
            tag2_fetch_q <= tag2_fetch_d;
            if_rvalid_q  <= if_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: grants, memory strobes and read returns
// are predicted from a shadow memory and checked every cycle on the falling edge.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 3;

    logic              clk = 1'b0;
    logic              rst, halt;
    logic              if_req, d_req, d_we;
    logic [ADDR_W-1:0] if_addr, d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              if_gnt, if_rvalid, d_gnt, d_rvalid;
    logic [DATA_W-1:0] if_rdata, d_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned       due;
        logic              fetch;
        logic [DATA_W-1:0] data;
    } rd_t;

    typedef struct {
        int unsigned       due;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_t;

    rd_t  rq[$];
    mem_t mq[$];

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] init_word(input int unsigned a);
        return (a == 5) ? 32'h2842_000A : ((a * 32'h0101_0101) ^ 32'hA5A5_0000);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory: read data appears the cycle after mem_en.
    initial begin
        logic [DATA_W-1:0] mem [1 << ADDR_W];
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = init_word(i);
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_en === 1'b1 && mem_we === 1'b1) mem[mem_addr] = mem_wdata;
            if (mem_en === 1'b1 && mem_we === 1'b0) mem_rdata <= mem[mem_addr];
        end
    end

    // Scoreboard monitor.
    initial begin
        logic [DATA_W-1:0] shadow [1 << ADDR_W];
        logic [DATA_W-1:0] exp_if_rd, exp_d_rd;
        logic              rst_prev, ev_f, ev_d, ed, ef, fw;
        int unsigned       scnt;
        rd_t               r;
        mem_t              m;
        for (int i = 0; i < (1 << ADDR_W); i++) shadow[i] = init_word(i);
        exp_if_rd = '0;
        exp_d_rd  = '0;
        rst_prev  = 1'b0;
        scnt      = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check_eq("gnt_in_rst", 64'({if_gnt, d_gnt}), 64'(0));
                if (rst_prev)
                    check_eq("out_in_rst", 64'(|{if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                                                 mem_en, mem_we, mem_addr, mem_wdata}), 64'(0));
                rq.delete();
                mq.delete();
                exp_if_rd = '0;
                exp_d_rd  = '0;
                scnt      = 0;
            end else begin
                if (mq.size() > 0 && mq[0].due == cyc) begin
                    m = mq.pop_front();
                    check_eq("mem_en", 64'(mem_en), 64'(1));
                    check_eq("mem_we", 64'(mem_we), 64'(m.we));
                    check_eq("mem_addr", 64'(mem_addr), 64'(m.addr));
                    if (m.we) check_eq("mem_wdata", 64'(mem_wdata), 64'(m.wdata));
                end else begin
                    check_eq("mem_idle", 64'(mem_en), 64'(0));
                end

                ev_f = 1'b0;
                ev_d = 1'b0;
                if (rq.size() > 0 && rq[0].due == cyc) begin
                    r = rq.pop_front();
                    if (r.fetch) begin ev_f = 1'b1; exp_if_rd = r.data; end
                    else         begin ev_d = 1'b1; exp_d_rd  = r.data; end
                end
                check_eq("rvalid", 64'({if_rvalid, d_rvalid}), 64'({ev_f, ev_d}));
                check_eq("if_rdata", 64'(if_rdata), 64'(exp_if_rd));
                check_eq("d_rdata", 64'(d_rdata), 64'(exp_d_rd));

`ifdef MEM_PORT_ARBITER_STARVE_EN
                fw = if_req && (scnt == STARVE_MAX);
`else
                fw = 1'b0;
`endif
                ed = !halt && d_req && !fw;
                ef = !halt && if_req && !ed;
                check_eq("gnt", 64'({if_gnt, d_gnt}), 64'({ef, ed}));

                if (ed) begin
                    if (d_we) shadow[d_addr] = d_wdata;
                    else rq.push_back('{due: cyc + 3, fetch: 1'b0, data: shadow[d_addr]});
                    mq.push_back('{due: cyc + 1, we: d_we, addr: d_addr, wdata: d_wdata});
                end else if (ef) begin
                    rq.push_back('{due: cyc + 3, fetch: 1'b1, data: shadow[if_addr]});
                    mq.push_back('{due: cyc + 1, we: 1'b0, addr: if_addr, wdata: '0});
                end
                if (!if_req || ef) scnt = 0;
                else if (ed)       scnt++;
            end
            rst_prev = rst;
        end
    end

    initial begin
        logic [7:0] pat;
        logic [7:0] exp_pat;
        logic       dg, fg;
        rst = 1'b1; halt = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Lone fetch of word 5.
        if_req = 1'b1; if_addr = 10'd5;
        step();
        if_req = 1'b0;
        repeat (4) step();

        // Store 99 to word 20, then load it back on the very next cycle.
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'd20; d_wdata = 32'd99;
        step();
        d_we = 1'b0;
        step();
        d_req = 1'b0;
        repeat (4) step();

        // Contention for 8 cycles.
        if_req = 1'b1; if_addr = 10'd3;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd20;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pat[7 - i] = d_gnt;
            step();
        end
        if_req = 1'b0; d_req = 1'b0;
`ifdef MEM_PORT_ARBITER_STARVE_EN
        exp_pat = 8'b1110_1110;
`else
        exp_pat = 8'b1111_1111;
`endif
        check_eq("contend_pat", 64'(pat), 64'(exp_pat));
        repeat (4) step();

        // Read then halt for 4 cycles; the read still returns.
        if_req = 1'b1; if_addr = 10'd7;
        step();
        halt = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd8;
        repeat (4) step();
        halt = 1'b0; if_req = 1'b0; d_req = 1'b0;
        repeat (4) step();

        // Read, then reset on the next cycle drops it; transfer right after reset.
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd5;
        step();
        d_req = 1'b0; rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd20;
        @(negedge clk);
        check_eq("gnt_after_rst", 64'(d_gnt), 64'(1));
        step();
        d_req = 1'b0;
        repeat (4) step();

        // Randomized traffic; requesters hold until granted.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            dg = d_req && d_gnt;
            fg = if_req && if_gnt;
            step();
            if (!d_req || dg) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = ADDR_W'($urandom_range(0, 15));
                d_wdata = $urandom;
            end
            if (!if_req || fg) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = ADDR_W'($urandom_range(0, 15));
            end
            halt = ($urandom_range(0, 7) == 0);
        end
        halt = 1'b0; if_req = 1'b0; d_req = 1'b0;
        repeat (6) step();
        check_eq("drain", 64'(rq.size() + mq.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
